// File: rtl/ttl_pkg.sv
// Shared constants for the TTL-style counter family.
`timescale 1ns/1ps
`default_nettype none

package ttl_pkg;

  localparam int TTL_NIBBLE = 4;
  localparam int DELAY_RISE = 15;
  localparam int DELAY_FALL = 15;

endpackage

`default_nettype wire

// File: rtl/ttl_down_nibble.sv
// One 4-bit down-counting stage with parallel load, lookahead enable and borrow-out.
`timescale 1ns/1ps
`default_nettype none

module ttl_down_nibble
  import ttl_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Clear_bar,
  input  logic                  Load_bar,
  input  logic                  TE,
  input  logic                  ENP,
  input  logic                  reload,
  input  logic [TTL_NIBBLE-1:0] D,
  output logic [TTL_NIBBLE-1:0] Q,
  output logic                  BO
);

  logic [TTL_NIBBLE-1:0] count_q;
  logic [TTL_NIBBLE-1:0] count_d;

  // A top-level reload is just a load forced on the terminal-count edge.
  always_comb begin
    count_d = count_q;
    if (!Load_bar || reload) begin
      count_d = D;
    end else if (TE && ENP) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge Clk or negedge Clear_bar) begin
    if (!Clear_bar) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign Q  = count_q;
  assign BO = TE && (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/ttl_preset_down_counter.sv
// Presettable synchronous down counter built from cascaded 4-bit stages, optional auto-reload.
`timescale 1ns/1ps
`default_nettype none

module ttl_preset_down_counter #(
  parameter int STAGES      = 2,
  parameter int AUTO_RELOAD = 0,
  parameter int DELAY_RISE  = ttl_pkg::DELAY_RISE,
  parameter int DELAY_FALL  = ttl_pkg::DELAY_FALL
) (
  input  logic                                  Clk,
  input  logic                                  Clear_bar,
  input  logic                                  Load_bar,
  input  logic                                  ENT,
  input  logic                                  ENP,
  input  logic [ttl_pkg::TTL_NIBBLE*STAGES-1:0] D,
  output logic                                  BO,
  output logic [ttl_pkg::TTL_NIBBLE*STAGES-1:0] Q
);

  localparam int NIB = ttl_pkg::TTL_NIBBLE;
  localparam int N   = NIB * STAGES;

  logic [N-1:0] w_q;
  logic         w_bo;
  logic         w_reload;

  // Trickle enable is chained per stage so each TE depends only on lower stages.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic w_te;
    logic w_bo_k;

    if (k == 0) begin : g_first
      assign w_te = ENT;
    end else begin : g_next
      assign w_te = g_stage[k-1].w_bo_k;
    end

    ttl_down_nibble u_nibble (
      .Clk       (Clk),
      .Clear_bar (Clear_bar),
      .Load_bar  (Load_bar),
      .TE        (w_te),
      .ENP       (ENP),
      .reload    (w_reload),
      .D         (D[k*NIB +: NIB]),
      .Q         (w_q[k*NIB +: NIB]),
      .BO        (w_bo_k)
    );
  end

  assign w_bo     = g_stage[STAGES-1].w_bo_k;
  assign w_reload = (AUTO_RELOAD != 0) && w_bo && ENP && Load_bar;

  logic [N:0] w_pre;
  logic [N:0] w_rise;
  logic [N:0] w_fall;
  logic [N:0] w_out;

  assign w_pre = {w_bo, w_q};
  assign #(DELAY_RISE) w_rise = w_pre;
  assign #(DELAY_FALL) w_fall = w_pre;

  // Combining the two delayed copies lets rising edges take DELAY_RISE and falling DELAY_FALL.
  if (DELAY_RISE <= DELAY_FALL) begin : g_rise_first
    assign w_out = w_rise | w_fall;
  end else begin : g_fall_first
    assign w_out = w_rise & w_fall;
  end

  assign {BO, Q} = w_out;

endmodule

`default_nettype wire

// File: tb/tb_ttl_preset_down_counter.sv
// Directed + randomized check of ttl_preset_down_counter against a behavioural model.
`timescale 1ns/1ps
`default_nettype none

module tb_ttl_preset_down_counter;

  localparam int N    = 8;
  localparam int MAXV = (1 << N) - 1;

  logic         Clk = 1'b0;
  logic         Clear_bar;
  logic         Load_bar;
  logic         ENT;
  logic         ENP;
  logic [N-1:0] D;
  logic [N-1:0] Q0, Q1;
  logic         BO0, BO1;

  int vectors     = 0;
  int miscompares = 0;
  int m0 = 0;
  int m1 = 0;

  always #50 Clk = ~Clk;

  ttl_preset_down_counter #(.STAGES(2), .AUTO_RELOAD(0), .DELAY_RISE(15), .DELAY_FALL(15)) u_dut0 (
    .Clk(Clk), .Clear_bar(Clear_bar), .Load_bar(Load_bar), .ENT(ENT), .ENP(ENP),
    .D(D), .BO(BO0), .Q(Q0)
  );

  ttl_preset_down_counter #(.STAGES(2), .AUTO_RELOAD(1), .DELAY_RISE(15), .DELAY_FALL(15)) u_dut1 (
    .Clk(Clk), .Clear_bar(Clear_bar), .Load_bar(Load_bar), .ENT(ENT), .ENP(ENP),
    .D(D), .BO(BO1), .Q(Q1)
  );

  function automatic int model_next(input int cur, input bit auto_reload);
    if (!Load_bar) return int'(D);
    if (ENT && ENP) begin
      if (cur == 0) return auto_reload ? int'(D) : MAXV;
      return cur - 1;
    end
    return cur;
  endfunction

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0] e0, e1;
    e0 = m0[N-1:0];
    e1 = m1[N-1:0];
    check({tag, " Q0"}, Q0, e0);
    check({tag, " BO0"}, {7'd0, BO0}, {7'd0, ENT && (m0 == 0)});
    check({tag, " Q1"}, Q1, e1);
    check({tag, " BO1"}, {7'd0, BO1}, {7'd0, ENT && (m1 == 0)});
  endtask

  task automatic tick(input string tag);
    @(posedge Clk);
    if (!Clear_bar) begin
      m0 = 0;
      m1 = 0;
    end else begin
      m0 = model_next(m0, 1'b0);
      m1 = model_next(m1, 1'b1);
    end
    @(negedge Clk);
    check_all(tag);
  endtask

  initial begin
    int bo_high;
    logic [N-1:0] seq [8];

    Clear_bar = 1'b0;
    Load_bar  = 1'b1;
    ENT       = 1'b0;
    ENP       = 1'b0;
    D         = '0;

    #20;
    check("reset Q", Q0, 8'h00);
    check("reset BO ENT=0", {7'd0, BO0}, 8'h00);
    ENT = 1'b1;
    #20;
    check("reset BO ENT=1", {7'd0, BO0}, 8'h01);

    @(negedge Clk);
    Clear_bar = 1'b1;

    // Asynchronous clear between edges, observed through the output delay.
    Load_bar = 1'b0; D = 8'h5A; ENP = 1'b0;
    tick("load 5A");
    Load_bar = 1'b1;
    Clear_bar = 1'b0;
    #10;
    check("clear before delay", Q0, 8'h5A);
    #7;
    check("clear after delay", Q0, 8'h00);
    check("clear BO", {7'd0, BO0}, 8'h01);
    m0 = 0;
    m1 = 0;
    @(negedge Clk);
    Clear_bar = 1'b1;

    ENT = 1'b0; ENP = 1'b0; Load_bar = 1'b0; D = 8'h12;
    tick("load 12");
    Load_bar = 1'b1;
    tick("hold 12");

    Load_bar = 1'b0; D = 8'h10;
    tick("load 10");
    Load_bar = 1'b1; ENT = 1'b1; ENP = 1'b1;
    tick("borrow 10->0F");
    check("borrow value", Q0, 8'h0F);

    Load_bar = 1'b0; D = 8'h00;
    tick("load 00 enabled");
    check("BO at zero", {7'd0, BO0}, 8'h01);
    Load_bar = 1'b1;
    tick("wrap");
    check("wrap FF", Q0, 8'hFF);
    check("reload D=0 stuck", Q1, 8'h00);
    Load_bar = 1'b0; ENT = 1'b0;
    tick("zero ENT low");

    D = 8'h03;
    tick("load 03");
    Load_bar = 1'b1; ENT = 1'b1; ENP = 1'b1;
    seq = '{8'h02, 8'h01, 8'h00, 8'h03, 8'h02, 8'h01, 8'h00, 8'h03};
    bo_high = 0;
    for (int i = 0; i < 8; i++) begin
      tick("autoreload");
      check("autoreload seq", Q1, seq[i]);
      if (BO1) bo_high++;
    end
    check("autoreload BO count", bo_high[N-1:0], 8'd2);

    ENP = 1'b0; ENT = 1'b1;
    tick("hold ENP=0");
    ENP = 1'b1; Load_bar = 1'b0; D = 8'h77;
    tick("load beats count");
    check("load priority", Q0, 8'h77);
    Clear_bar = 1'b0;
    tick("clear beats load");
    check("clear priority", Q1, 8'h00);
    Clear_bar = 1'b1;
    Load_bar = 1'b1;

    for (int i = 0; i < 300; i++) begin
      Clear_bar = ($urandom_range(0, 31) != 0);
      Load_bar  = ($urandom_range(0, 7) != 0);
      ENT       = ($urandom_range(0, 5) != 0);
      ENP       = ($urandom_range(0, 5) != 0);
      D         = N'($urandom_range(0, 15) == 0 ? $urandom_range(0, 3) : $urandom);
      tick("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
